// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and traceback FSM encoding.
// Optional macro TB_STATE_OUT_EN adds tb_state to the traceback unit.
package viterbi_pkg;

    localparam int VIT_K = 5;
    localparam int VIT_M = VIT_K - 1;
    localparam int VIT_S = 1 << VIT_M;
    localparam int VIT_D = 10;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        OUT
    } tb_fsm_e;

endpackage

// File: rtl/traceback_unit.sv
// Survivor-memory traceback: walks D-1 rows back from best_state, emits one bit.
// Define TB_STATE_OUT_EN to expose the final traced state on tb_state.
module traceback_unit
    import viterbi_pkg::*;
#(
    parameter int K = VIT_K,
    parameter int M = K - 1,
    parameter int S = 1 << M,
    parameter int D = VIT_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_frame,
    input  logic                   row_written,
    input  logic [$clog2(D)-1:0]   wr_ptr,
    input  logic                   start,
    input  logic [$clog2(S)-1:0]   best_state,
    output logic [$clog2(S)-1:0]   rd_state,
    output logic [$clog2(D)-1:0]   rd_time,
    input  logic                   surv_bit,
    output logic                   busy,
    output logic                   dec_valid,
    output logic                   dec_bit,
    input  logic                   dec_ready,
    output logic                   start_drop
`ifdef TB_STATE_OUT_EN
    ,
    output logic [$clog2(S)-1:0]   tb_state
`endif
);

    localparam int DW = $clog2(D);

    tb_fsm_e       state;
    logic [DW-1:0] fill_cnt;
    logic [DW-1:0] cnt;
    logic          filled;

    assign filled = (fill_cnt == DW'(D - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            cnt        <= '0;
            rd_state   <= '0;
            rd_time    <= '0;
            dec_bit    <= 1'b0;
            dec_valid  <= 1'b0;
            busy       <= 1'b0;
            start_drop <= 1'b0;
`ifdef TB_STATE_OUT_EN
            tb_state   <= '0;
`endif
        end else if (init_frame) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            cnt        <= '0;
            dec_valid  <= 1'b0;
            busy       <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            if (row_written && !filled)
                fill_cnt <= fill_cnt + 1'b1;
            // Any start that cannot launch a traceback right now is lost.
            if (start && !(state == IDLE && filled))
                start_drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start && filled) begin
                        rd_state <= best_state;
                        rd_time  <= (wr_ptr == '0) ? DW'(D - 1)
                                                   : wr_ptr - 1'b1;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= TRACE;
                    end
                end
                TRACE: begin
                    if (cnt < DW'(D - 2)) begin
                        rd_state <= {surv_bit, rd_state[M-1:1]};
                        rd_time  <= (rd_time == '0) ? DW'(D - 1)
                                                    : rd_time - 1'b1;
                        cnt      <= cnt + 1'b1;
                    end else begin
                        dec_bit   <= rd_state[0];
                        dec_valid <= 1'b1;
                        state     <= OUT;
`ifdef TB_STATE_OUT_EN
                        tb_state  <= rd_state;
`endif
                    end
                end
                OUT: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
